// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered 8-digit 7-segment scan controller.
// Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       commit,
  output logic       commit_done,
  output logic [7:0] display,
  output logic [7:0] segment
);

  typedef enum logic {GAP, ON} state_t;

  localparam logic [19:0] LAST = 20'(SCAN_DIV - 1);

  logic [3:0]  shadow [8];
  logic [3:0]  active [8];
  logic        pending;
  state_t      state;
  logic [2:0]  idx;
  logic [19:0] cnt;
  logic        wr_fire;
  logic        boundary;
  logic [3:0]  shown;
  logic [7:0]  seg_nxt;

  function automatic logic [7:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = ~8'h3F;
      4'd1:    enc = ~8'h06;
      4'd2:    enc = ~8'h5B;
      4'd3:    enc = ~8'h4F;
      4'd4:    enc = ~8'h66;
      4'd5:    enc = ~8'h6D;
      4'd6:    enc = ~8'h7D;
      4'd7:    enc = ~8'h27;
      4'd8:    enc = ~8'h7F;
      4'd9:    enc = ~8'h6F;
      default: enc = 8'hFF;
    endcase
  endfunction

  assign wr_ready = !pending;
  assign wr_fire  = wr_valid && wr_ready;
  // Last ON cycle of digit 7 with a commit waiting: the frame swap point.
  assign boundary = (state == ON) && (cnt == LAST)
                 && (idx == 3'd7) && pending;

  // Producers fill the shadow frame; it is never scanned directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) shadow[i] <= 4'd10;
    end else if (wr_fire) begin
      shadow[wr_digit] <= wr_value;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic zb_above;

  // Value to show for the current digit, with leading zeros blanked.
  always_comb begin
    shown    = active[idx];
    zb_above = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (3'(k) == idx && active[k] == 4'd0 && zb_above)
        shown = 4'd15;
      zb_above = zb_above
              && (active[k] == 4'd0 || active[k] > 4'd9);
    end
  end
`else
  // Value to show for the current digit, exactly as written.
  always_comb begin
    shown = active[idx];
  end
`endif

  // Segment pattern for the digit about to be lit.
  always_comb begin
    seg_nxt = enc(shown);
  end

  // Scan FSM, commit handshake and active-frame swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= GAP;
      idx         <= 3'd0;
      cnt         <= 20'd0;
      display     <= 8'hFF;
      segment     <= 8'hFF;
      pending     <= 1'b0;
      commit_done <= 1'b0;
      for (int i = 0; i < 8; i++) active[i] <= 4'd10;
    end else begin
      commit_done <= boundary;
      if (boundary)
        pending <= 1'b0;
      else if (commit)
        pending <= 1'b1;
      if (boundary)
        active <= shadow;
      case (state)
        GAP: begin
          state   <= ON;
          cnt     <= 20'd1;
          display <= ~(8'b1 << idx);
          segment <= seg_nxt;
        end
        ON: begin
          if (cnt == LAST) begin
            state   <= GAP;
            cnt     <= 20'd0;
            idx     <= idx + 3'd1;
            display <= 8'hFF;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (SCAN_DIV=4).
// Expectations follow SEG_LZ_BLANK_EN when that macro is defined.
module tb_seg_scan_ctrl;

  localparam int SD  = 4;
  localparam int LIM = 8 * SD + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_digit = 3'd0;
  logic [3:0] wr_value = 4'd0;
  logic       commit = 1'b0;
  logic       commit_done;
  logic [7:0] display;
  logic [7:0] segment;

  typedef struct {
    logic [2:0] dig;
    logic [7:0] seg;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] dq[$];
  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_digit(wr_digit), .wr_value(wr_value),
    .commit(commit), .commit_done(commit_done),
    .display(display), .segment(segment)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [2:0] d, input logic [7:0] s);
    exp_t e;
    e.dig = d;
    e.seg = s;
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [2:0] d, input logic [3:0] v);
    wr_valid = 1'b1;
    wr_digit = d;
    wr_value = v;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready d%0d: got %b want 1", d, wr_ready);
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    @(posedge clk);
    #1 commit = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output logic [7:0] prev);
    ok = 1'b0;
    prev = 8'hxx;
    for (int n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (commit_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      prev = display;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL commit_done timeout: got 0 want 1");
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    bit   found;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      found = 1'b0;
      for (int n = 0; n < LIM; n++) begin
        @(negedge clk);
        if (display === ~(8'b1 << e.dig)) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s d%0d: digit never lit", tag, e.dig);
      end else if (segment !== e.seg) begin
        errors++;
        $display("FAIL %s d%0d seg: got %h want %h",
                 tag, e.dig, segment, e.seg);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (display !== 8'hFF) begin
      errors++;
      $display("FAIL rst display: got %h want ff", display);
    end
    if (segment !== 8'hFF) begin
      errors++;
      $display("FAIL rst segment: got %h want ff", segment);
    end
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst wr_ready: got %b want 1", wr_ready);
    end
    if (commit_done !== 1'b0) begin
      errors++;
      $display("FAIL rst commit_done: got %b want 0", commit_done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_blank_scan();
    logic [7:0] d;
    logic [7:0] s;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) begin
        dq.push_back(8'hFF);
        for (int c = 1; c < SD; c++)
          dq.push_back(~(8'b1 << k));
      end
    dq.push_back(8'hFF);
    dq.push_back(8'hFE);
    while (dq.size() > 0) begin
      d = dq.pop_front();
      @(negedge clk);
      s = segment;
      checks++;
      if (display !== d || s !== 8'hFF) begin
        errors++;
        $display("FAIL blank_scan: got %h/%h want %h/ff",
                 display, s, d);
      end
    end
  endtask

  task automatic test_write_commit();
    bit         ok;
    logic [7:0] prev;
    wr(3'd0, 4'd1);
    wr(3'd1, 4'd2);
    wr(3'd2, 4'd3);
    wr(3'd3, 4'd4);
    commit_pulse();
    wait_done(ok, prev);
    checks += 2;
    if (prev !== 8'h7F) begin
      errors++;
      $display("FAIL boundary prev: got %h want 7f", prev);
    end
    if (display !== 8'hFF) begin
      errors++;
      $display("FAIL boundary gap: got %h want ff", display);
    end
    @(negedge clk);
    checks++;
    if (commit_done !== 1'b0) begin
      errors++;
      $display("FAIL done pulse: got %b want 0", commit_done);
    end
    push(3'd0, 8'hF9);
    push(3'd1, 8'hA4);
    push(3'd2, 8'hB0);
    push(3'd3, 8'h99);
    for (int k = 4; k < 8; k++) push(3'(k), 8'hFF);
    drain("commit");
  endtask

  task automatic test_backpressure();
    bit         ok;
    bit         bad;
    logic [7:0] prev;
    commit_pulse();
    wr_valid = 1'b1;
    wr_digit = 3'd5;
    wr_value = 4'd9;
    bad = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (commit_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (wr_ready !== 1'b0) bad = 1'b1;
    end
    checks += 3;
    if (!ok) begin
      errors++;
      $display("FAIL bp done: got 0 want 1");
    end
    if (bad) begin
      errors++;
      $display("FAIL bp wr_ready: got 1 want 0 while pending");
    end
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp release: got %b want 1", wr_ready);
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
    push(3'd0, 8'hF9);
    push(3'd3, 8'h99);
    push(3'd5, 8'hFF);
    drain("backpressure");
  endtask

  task automatic test_simultaneous();
    bit         ok;
    logic [7:0] prev;
    int         extra;
    wr_valid = 1'b1;
    wr_digit = 3'd2;
    wr_value = 4'd7;
    commit = 1'b1;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(posedge clk);
    #1 commit = 1'b0;
    wait_done(ok, prev);
    push(3'd0, 8'hF9);
    push(3'd1, 8'hA4);
    push(3'd2, 8'hD8);
    push(3'd3, 8'h99);
    push(3'd4, 8'hFF);
    push(3'd5, 8'h90);
    push(3'd6, 8'hFF);
    drain("simul");
    extra = 0;
    for (int n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (commit_done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL double commit: got %0d extra want 0", extra);
    end
  endtask

  task automatic test_lz();
    bit         ok;
    logic [7:0] prev;
    wr(3'd0, 4'd0);
    wr(3'd1, 4'd0);
    wr(3'd2, 4'd5);
    for (int k = 3; k < 8; k++) wr(3'(k), 4'd0);
    commit_pulse();
    wait_done(ok, prev);
    push(3'd0, 8'hC0);
    push(3'd1, 8'hC0);
    push(3'd2, 8'h92);
`ifdef SEG_LZ_BLANK_EN
    for (int k = 3; k < 8; k++) push(3'(k), 8'hFF);
`else
    for (int k = 3; k < 8; k++) push(3'(k), 8'hC0);
`endif
    drain("lz");
  endtask

  task automatic test_reset_pending();
    int dones;
    bit lit_bad;
    wr(3'd4, 4'd8);
    commit_pulse();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks += 2;
    if (display !== 8'hFF) begin
      errors++;
      $display("FAIL rst_pend display: got %h want ff", display);
    end
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pend wr_ready: got %b want 1", wr_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dones = 0;
    lit_bad = 1'b0;
    for (int n = 0; n < 2 * LIM; n++) begin
      @(negedge clk);
      if (commit_done === 1'b1) dones++;
      if (display !== 8'hFF && segment !== 8'hFF) lit_bad = 1'b1;
    end
    checks += 2;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_pend done: got %0d want 0", dones);
    end
    if (lit_bad) begin
      errors++;
      $display("FAIL rst_pend frame: got lit segment want ff");
    end
  endtask

  initial begin
    test_reset();
    test_blank_scan();
    test_write_commit();
    test_backpressure();
    test_simultaneous();
    test_lz();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
